// File: rtl/mont_r2_precompute_pkg.sv
// Shared definitions for the Montgomery R^2 precompute engine.
// Holds the default operand width, FSM encoding and counter sizing helper.
package mont_r2_precompute_pkg;

    localparam int unsigned K_BITS_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Step counter must hold 2*K-1 with headroom.
    function automatic int unsigned cnt_width(input int unsigned k);
        return $clog2(2 * k) + 1;
    endfunction

endpackage

// File: rtl/mont_r2_precompute_if.sv
// Start/done request bus between a controller and the R^2 precompute engine.
import mont_r2_precompute_pkg::*;

interface mont_r2_precompute_if #(
    parameter int unsigned K_BITS = K_BITS_DEF
);
    logic              i_Start;
    logic [K_BITS-1:0] i_m;
    logic [K_BITS-1:0] o_R2;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Err;

    modport master (
        output i_Start, i_m,
        input  o_R2, o_Busy, o_Done, o_Err
    );

    modport slave (
        input  i_Start, i_m,
        output o_R2, o_Busy, o_Done, o_Err
    );
endinterface

// File: rtl/mont_r2_precompute_dbl_sub.sv
// Combinational modular doubling: 2r mod m, assuming r < m < 2^K_BITS.
import mont_r2_precompute_pkg::*;

module mont_r2_precompute_dbl_sub #(
    parameter int unsigned K_BITS = K_BITS_DEF
) (
    input  logic [K_BITS-1:0] i_r,
    input  logic [K_BITS-1:0] i_m,
    output logic [K_BITS-1:0] o_r_c
);
    logic [K_BITS:0] w_r2x;
    logic [K_BITS:0] w_diff;
    logic            w_ge;

    // 2r < 2m, so one conditional subtract brings the result back below m.
    always_comb begin
        w_r2x  = {i_r, 1'b0};
        w_diff = w_r2x - {1'b0, i_m};
        w_ge   = (w_r2x >= {1'b0, i_m});
        o_r_c  = w_ge ? K_BITS'(w_diff) : K_BITS'(w_r2x);
    end
endmodule

// File: rtl/mont_r2_precompute.sv
// Computes R2 = 2^(2*K_BITS) mod m by 2*K_BITS modular doublings of r = 1.
// Even or zero moduli are rejected with o_Err after a single RUN cycle.
import mont_r2_precompute_pkg::*;

module mont_r2_precompute #(
    parameter int unsigned K_BITS = K_BITS_DEF
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    mont_r2_precompute_if.slave           bus
);
    localparam int unsigned CNT_W = cnt_width(K_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * K_BITS - 1);

    state_e              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [K_BITS-1:0]   r_r, w_r_next;
    logic [K_BITS-1:0]   r_m, w_m_next;
    logic [K_BITS-1:0]   r_R2, w_R2_next;
    logic                r_Busy, w_Busy_next;
    logic                r_Done, w_Done_next;
    logic                r_Err, w_Err_next;
    logic [K_BITS-1:0]   w_r_dbl;

    mont_r2_precompute_dbl_sub #(.K_BITS(K_BITS)) u_dbl_sub (
        .i_r   (r_r),
        .i_m   (r_m),
        .o_r_c (w_r_dbl)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_r     <= '0;
            r_m     <= '0;
            r_R2    <= '0;
            r_Busy  <= 1'b0;
            r_Done  <= 1'b0;
            r_Err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_r     <= w_r_next;
            r_m     <= w_m_next;
            r_R2    <= w_R2_next;
            r_Busy  <= w_Busy_next;
            r_Done  <= w_Done_next;
            r_Err   <= w_Err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_r_next     = r_r;
        w_m_next     = r_m;
        w_R2_next    = r_R2;
        w_Busy_next  = r_Busy;
        w_Done_next  = 1'b0;
        w_Err_next   = r_Err;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    w_m_next     = bus.i_m;
                    w_Busy_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                    if (!bus.i_m[0]) begin
                        w_Err_next = 1'b1;
                        w_R2_next  = '0;
                        w_r_next   = '0;
                    end else begin
                        w_Err_next = 1'b0;
                        w_r_next   = (bus.i_m == K_BITS'(1)) ? '0 : K_BITS'(1);
                    end
                end
            end
            ST_RUN: begin
                // A rejected modulus passes through RUN once so o_Done lands one edge after start.
                if (r_Err) begin
                    w_Done_next  = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_r_next   = w_r_dbl;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_R2_next    = w_r_dbl;
                        w_Done_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_Busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_Busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.o_R2   = r_R2;
    assign bus.o_Busy = r_Busy;
    assign bus.o_Done = r_Done;
    assign bus.o_Err  = r_Err;
endmodule
